// File: rtl/capture_scheduler_pkg.sv
// Shared types and defaults for the capture scheduler.
// States: IDLE waits for req, RUN counts, LATCH grabs the count, HOLD offers it, RELEASE waits for reload.
package capture_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_LATCH   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [31:0] TIMEOUT_DEFAULT = 32'h00FF_FFFF;

  function automatic int ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/capture_scheduler_rr_arbiter.sv
// Round-robin pick: first requesting channel at or after rr_ptr, wrapping.
module capture_scheduler_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   id,
  output logic              any
);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;
  logic [CH_W:0]       offset;
  logic [CH_W:0]       sum;

  assign any = |req;

  // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit is the winner.
  always_comb begin
    req_dbl = {req, req} >> rr_ptr;
    req_rot = req_dbl[NUM_CH-1:0];
    offset  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = (CH_W+1)'(i);
    end
    sum = {1'b0, rr_ptr} + offset;
    if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
    id    = sum[CH_W-1:0];
    grant = any ? (NUM_CH'(1) << id) : '0;
  end

endmodule

// File: rtl/capture_scheduler.sv
// Shares one capture_counter between NUM_CH requesters: round-robin grant, gate
// handshake, watchdog stop and a valid/ready result port.
module capture_scheduler
  import capture_scheduler_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          CH_W    = ch_width(NUM_CH),
  parameter logic [31:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] gate_in,
  input  logic [31:0]       cnt_value,
  input  logic              cnt_complete,
  output logic              timer_enable,
  output logic              cap_gate,
  output logic [NUM_CH-1:0] grant,
  output logic              busy,
  output logic [31:0]       result_data,
  output logic [CH_W-1:0]   result_id,
  output logic              result_timeout,
  output logic              result_valid,
  input  logic              result_ready
);

  state_t            state_q, state_nxt;
  logic [CH_W-1:0]   rr_ptr_q, cur_id_q, rr_next;
  logic [CH_W:0]     id_inc;
  logic [31:0]       wd_cnt_q;
  logic              wd_force_q, wd_trip, wd_force, to_flag_q;
  logic              start, latch, accept;
  logic [NUM_CH-1:0] arb_grant;
  logic [CH_W-1:0]   arb_id;
  logic              arb_any;

  capture_scheduler_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .id     (arb_id),
    .any    (arb_any)
  );

  assign wd_trip  = (state_q == ST_RUN) && (wd_cnt_q == TIMEOUT - 32'd1);
  assign wd_force = wd_force_q | wd_trip;
  assign busy     = (state_q != ST_IDLE);
  assign id_inc   = {1'b0, cur_id_q} + (CH_W+1)'(1);
  assign rr_next  = (id_inc == (CH_W+1)'(NUM_CH)) ? '0 : id_inc[CH_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    cap_gate  = 1'b0;
    start     = 1'b0;
    latch     = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          start     = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        cap_gate = gate_in[cur_id_q] | wd_force;
        if (cnt_complete) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        latch     = 1'b1;
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (result_ready) begin
          accept    = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!cnt_complete) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q       <= '0;
      cur_id_q       <= '0;
      grant          <= '0;
      timer_enable   <= 1'b0;
      wd_cnt_q       <= '0;
      wd_force_q     <= 1'b0;
      to_flag_q      <= 1'b0;
      result_data    <= '0;
      result_id      <= '0;
      result_timeout <= 1'b0;
      result_valid   <= 1'b0;
    end else begin
      if (start) begin
        grant        <= arb_grant;
        cur_id_q     <= arb_id;
        timer_enable <= 1'b1;
        wd_cnt_q     <= '0;
        wd_force_q   <= 1'b0;
        to_flag_q    <= 1'b0;
      end
      // wd_cnt freezes once the stop is forced, so it can never wrap.
      if (state_q == ST_RUN) begin
        if (!wd_force) wd_cnt_q <= wd_cnt_q + 32'd1;
        if (wd_trip) begin
          wd_force_q <= 1'b1;
          to_flag_q  <= 1'b1;
        end
        if (cnt_complete) timer_enable <= 1'b0;
      end
      if (latch) begin
        result_data    <= cnt_value;
        result_id      <= cur_id_q;
        result_timeout <= to_flag_q;
        result_valid   <= 1'b1;
      end
      if (accept) begin
        result_valid <= 1'b0;
        rr_ptr_q     <= rr_next;
        grant        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_capture_scheduler.sv
// Randomised bench for capture_scheduler with a behavioural capture_counter and
// a result/arbitration reference model.
module tb_capture_scheduler;

  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int TIMEOUT = 50;

  logic              clk, reset;
  logic [NUM_CH-1:0] req, gate_in;
  logic [31:0]       cnt_value;
  logic              cnt_complete;
  logic              timer_enable, cap_gate, busy;
  logic [NUM_CH-1:0] grant;
  logic [31:0]       result_data;
  logic [CH_W-1:0]   result_id;
  logic              result_timeout, result_valid, result_ready;

  int errors = 0;
  int checks = 0;
  int rr_model = 0;
  int dly [NUM_CH];
  int first_gate_k = -1;
  int te_cnt = 0;
  int viol = 0;

  capture_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT(32'(TIMEOUT))) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .gate_in        (gate_in),
    .cnt_value      (cnt_value),
    .cnt_complete   (cnt_complete),
    .timer_enable   (timer_enable),
    .cap_gate       (cap_gate),
    .grant          (grant),
    .busy           (busy),
    .result_data    (result_data),
    .result_id      (result_id),
    .result_timeout (result_timeout),
    .result_valid   (result_valid),
    .result_ready   (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared capture_counter: counts from 1 while enabled, freezes on the gate, reloads when disabled.
  logic [31:0] cc_cnt;
  logic        cc_done;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cc_cnt  <= '0;
      cc_done <= 1'b0;
    end else if (!timer_enable) begin
      cc_cnt  <= '0;
      cc_done <= 1'b0;
    end else if (!cc_done) begin
      if (cap_gate) cc_done <= 1'b1;
      else          cc_cnt  <= cc_cnt + 32'd1;
    end
  end
  assign cnt_value    = cc_cnt;
  assign cnt_complete = cc_done;

  // Gate driver: pulses gate_in of the granted channel dly cycles after timer_enable rises.
  initial begin
    int k;
    int gid;
    k = -1;
    gate_in = '0;
    forever begin
      @(negedge clk);
      gid = -1;
      for (int c = 0; c < NUM_CH; c++) if (grant[c]) gid = c;
      if (timer_enable) begin
        k = k + 1;
        if (k == 0) first_gate_k = -1;
        if (cap_gate && first_gate_k < 0) first_gate_k = k;
      end else begin
        k = -1;
      end
      gate_in = '0;
      if (timer_enable && gid >= 0 && dly[gid] == k) gate_in[gid] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if ($countones(grant) > 1) viol++;
      if (timer_enable && grant == '0) viol++;
      if (cap_gate && !timer_enable) viol++;
      if (timer_enable) te_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NUM_CH-1:0] r, input int ptr);
    for (int i = 0; i < NUM_CH; i++) if (r[(ptr + i) % NUM_CH]) return (ptr + i) % NUM_CH;
    return -1;
  endfunction

  // Gate no later than the watchdog stop keeps its count; otherwise the stop lands at TIMEOUT-1.
  function automatic int exp_data(input int d);
    return (d >= 0 && d < TIMEOUT - 1) ? d : TIMEOUT - 1;
  endfunction

  function automatic int exp_tmo(input int d);
    return (d >= 0 && d < TIMEOUT - 2) ? 0 : 1;
  endfunction

  task automatic serve(input int hold, input bit drop);
    int n;
    int eid;
    int d;
    logic [31:0]     d0;
    logic [CH_W-1:0] id0;
    bit ok;
    eid = pick(req, rr_model);
    n = 0;
    while (!result_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("result_wait", result_valid, 1);
    d = dly[eid];
    chk("result_id", result_id, eid);
    chk("result_data", result_data, exp_data(d));
    chk("result_timeout", result_timeout, exp_tmo(d));
    chk("hold_grant", grant, 64'(1) << eid);
    d0 = result_data;
    id0 = result_id;
    ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (result_data !== d0 || result_id !== id0 || !result_valid || !busy ||
          grant !== NUM_CH'(1 << eid) || timer_enable) ok = 0;
    end
    if (hold > 0) chk("hold_stable", ok, 1);
    result_ready = 1'b1;
    if (drop) req[eid] = 1'b0;
    @(negedge clk);
    result_ready = 1'b0;
    chk("release_busy", busy, 1);
    chk("release_grant", grant, 0);
    chk("release_valid", result_valid, 0);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    rr_model = (eid + 1) % NUM_CH;
  endtask

  initial begin
    int n;
    int te0;
    reset = 1'b0;
    req = '0;
    result_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) dly[c] = 10;
    repeat (3) @(negedge clk);
    chk("rst_timer_enable", timer_enable, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_data", result_data, 0);
    reset = 1'b1;
    @(negedge clk);

    // Round robin with every channel requesting.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) serve(0, 0);
    req = '0;
    @(negedge clk);

    // Single channel: latency to timer_enable and its exact width.
    dly[1] = 30;
    req = 4'b0010;
    te0 = te_cnt;
    @(negedge clk);
    chk("req_to_te", timer_enable, 1);
    serve(0, 1);
    chk("te_width", te_cnt - te0, 32);

    // Reset mid-RUN, then arbitration restarts from channel 0.
    dly[0] = 15;
    dly[2] = -1;
    req = 4'b0101;
    n = 0;
    while (!timer_enable && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_grant", grant, 4'b0100);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_te", timer_enable, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cap_gate", cap_gate, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rr_model = 0;
    serve(0, 1);
    // Channel 2 never gates: watchdog stop.
    serve(0, 1);
    chk("wd_force_cycle", first_gate_k, TIMEOUT - 1);

    // Gate coincides with the watchdog trip.
    dly[2] = TIMEOUT - 1;
    req = 4'b0100;
    serve(0, 1);
    repeat (10) @(negedge clk);
    chk("single_result_valid", result_valid, 0);
    chk("single_result_busy", busy, 0);

    // Backpressure with another channel waiting.
    dly[3] = 20;
    dly[0] = 5;
    req = 4'b1001;
    serve(20, 1);
    @(negedge clk);
    chk("regrant_latency", timer_enable, 1);
    serve(0, 1);

    // Random patterns.
    for (int it = 0; it < 14; it++) begin
      int sel;
      req = NUM_CH'($urandom_range(1, 15));
      for (int c = 0; c < NUM_CH; c++) begin
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      dly[c] = -1;
        else if (sel == 1) dly[c] = TIMEOUT - 1 + int'($urandom_range(0, 5));
        else               dly[c] = int'($urandom_range(0, TIMEOUT - 4));
      end
      serve(int'($urandom_range(0, 4)), 1);
    end
    req = '0;
    repeat (5) @(negedge clk);
    chk("protocol_viol", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
